// File: rtl/kmeans_pkg.sv
// Shared widths, FSM encoding and field-offset helpers for the k-means mean update block.
package kmeans_pkg;

   localparam int unsigned PIX_W      = 8;
   localparam int unsigned CH         = 3;
   localparam int unsigned SUM_W      = 24;
   localparam int unsigned CNT_W      = 12;

   localparam int unsigned MEAN_W     = PIX_W * CH;   // one cluster's packed mean
   localparam int unsigned ACC_W      = SUM_W * CH;   // one cluster's packed sums
   localparam int unsigned DIVIDEND_W = SUM_W + 1;    // merged sum of two engines
   localparam int unsigned DIVISOR_W  = CNT_W + 1;    // merged count of two engines

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DIV,
      DONE
   } state_t;

   // Bit offset of engine e, cluster k, channel c in the accumolator bus.
   function automatic int unsigned acc_off(int unsigned e, int unsigned k, int unsigned c,
                                           int unsigned t);
      return e * ACC_W * t + k * ACC_W + c * SUM_W;
   endfunction

   // Bit offset of engine e, cluster k in the counters bus.
   function automatic int unsigned cnt_off(int unsigned e, int unsigned k, int unsigned t);
      return e * CNT_W * t + k * CNT_W;
   endfunction

   // Bit offset of cluster k, channel c in a mean bus.
   function automatic int unsigned mean_off(int unsigned k, int unsigned c);
      return k * MEAN_W + c * PIX_W;
   endfunction

endpackage

// File: rtl/mean_update_if.sv
// Request/result bundle between the k-means controller and the mean update block.
interface mean_update_if #(
   parameter int unsigned T = 16
);
   import kmeans_pkg::*;

   logic                     start;
   logic [ACC_W*T*2-1:0]     accumolator;
   logic [CNT_W*T*2-1:0]     counters;
   logic [MEAN_W*T-1:0]      meanIn;
   logic [T-1:0]             enabledIn;
   logic [MEAN_W*T-1:0]      meanOut;
   logic [T-1:0]             enabledOut;
   logic                     busy;
   logic                     done;
   logic                     converged;

   modport master (
      output start, accumolator, counters, meanIn, enabledIn,
      input  meanOut, enabledOut, busy, done, converged
   );

   modport slave (
      input  start, accumolator, counters, meanIn, enabledIn,
      output meanOut, enabledOut, busy, done, converged
   );

endinterface

// File: rtl/mean_div.sv
// 25-bit / 13-bit restoring divider producing an 8-bit quotient, one bit per cycle, MSB first.
// Only valid when the quotient fits in 8 bits; saturate flags the cases where it does not.
module mean_div
   import kmeans_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [PIX_W-1:0]      quotient,
   output logic                  ready,
   output logic                  saturate
);

   localparam int unsigned STEP_W = $clog2(PIX_W);

   logic [DIVISOR_W-1:0] rem_q;
   logic [PIX_W-1:0]     low_q;
   logic [PIX_W-1:0]     quo_q;
   logic [STEP_W-1:0]    step_q;
   logic                 active_q;

   logic [DIVISOR_W:0]   trial;
   logic [DIVISOR_W:0]   diff;
   logic                 ge;

   // Precheck plus one restoring step; quotient already includes the bit decided this cycle.
   always_comb begin
      saturate = dividend >= DIVIDEND_W'({divisor, {PIX_W{1'b0}}});
      trial    = {rem_q, low_q[PIX_W-1]};
      ge       = trial >= {1'b0, divisor};
      diff     = trial - {1'b0, divisor};
      quotient = {quo_q[PIX_W-2:0], ge};
      ready    = active_q && (step_q == STEP_W'(PIX_W - 1));
   end

   // Partial remainder starts as the dividend's upper bits, which are below the divisor
   // whenever the quotient fits in 8 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem_q    <= '0;
         low_q    <= '0;
         quo_q    <= '0;
         step_q   <= '0;
         active_q <= 1'b0;
      end else if (load) begin
         rem_q    <= dividend[PIX_W +: DIVISOR_W];
         low_q    <= dividend[PIX_W-1:0];
         quo_q    <= '0;
         step_q   <= '0;
         active_q <= 1'b1;
      end else if (active_q) begin
         rem_q    <= ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
         low_q    <= {low_q[PIX_W-2:0], 1'b0};
         quo_q    <= quotient;
         step_q   <= step_q + 1'b1;
         if (ready) active_q <= 1'b0;
      end
   end

endmodule

// File: rtl/mean_update.sv
// Merges the two cluster engines' sums and counts and divides them into new cluster means,
// reporting whether any enabled cluster's mean moved.
module mean_update
   import kmeans_pkg::*;
#(
   parameter int unsigned T = 16
) (
   input  logic            clk,
   input  logic            reset,
   mean_update_if.slave    bus
);

   localparam int unsigned KW = (T > 1) ? $clog2(T) : 1;

   state_t                 state_q;
   logic [KW-1:0]          k_q;
   logic [1:0]             c_q;
   logic [MEAN_W*T-1:0]    mean_q;
   logic [T-1:0]           en_q;
   logic                   changed_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   conv_q;

   logic [DIVIDEND_W-1:0]  sum;
   logic [DIVISOR_W-1:0]   cnt;
   logic                   skip;
   logic                   sat;
   logic                   div_load;
   logic                   div_ready;
   logic [PIX_W-1:0]       div_quo;
   logic [PIX_W-1:0]       old_val;
   logic [PIX_W-1:0]       wr_val;
   logic                   wr_en;
   logic                   wr_chg;
   logic                   adv_cl;
   logic                   finish;

   mean_div u_div (
      .clk      (clk),
      .reset    (reset),
      .load     (div_load),
      .dividend (sum),
      .divisor  (cnt),
      .quotient (div_quo),
      .ready    (div_ready),
      .saturate (sat)
   );

   // Merge the current cluster/channel across engines and decide the writeback for this cycle.
   always_comb begin
      sum = {1'b0, bus.accumolator[acc_off(32'd0, 32'(k_q), 32'(c_q), T) +: SUM_W]}
          + {1'b0, bus.accumolator[acc_off(32'd1, 32'(k_q), 32'(c_q), T) +: SUM_W]};
      cnt = {1'b0, bus.counters[cnt_off(32'd0, 32'(k_q), T) +: CNT_W]}
          + {1'b0, bus.counters[cnt_off(32'd1, 32'(k_q), T) +: CNT_W]};

      skip     = ~en_q[k_q] | (cnt == '0);
      old_val  = mean_q[mean_off(32'(k_q), 32'(c_q)) +: PIX_W];
      div_load = (state_q == LOAD) && !skip && !sat;
      wr_en    = ((state_q == LOAD) && !skip && sat) || ((state_q == DIV) && div_ready);
      wr_val   = (state_q == LOAD) ? {PIX_W{1'b1}} : div_quo;
      wr_chg   = wr_en && (wr_val != old_val);
      adv_cl   = ((state_q == LOAD) && skip) || (wr_en && (c_q == 2'd2));
      finish   = adv_cl && (k_q == KW'(T - 1));
   end

   // Control FSM, cluster/channel walk and registered results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         k_q       <= '0;
         c_q       <= '0;
         mean_q    <= '0;
         en_q      <= '0;
         changed_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         conv_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  mean_q    <= bus.meanIn;
                  en_q      <= bus.enabledIn;
                  changed_q <= 1'b0;
                  k_q       <= '0;
                  c_q       <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= LOAD;
               end
            end
            LOAD, DIV: begin
               if ((state_q == LOAD) && skip) en_q[k_q] <= 1'b0;
               if (wr_en) begin
                  mean_q[mean_off(32'(k_q), 32'(c_q)) +: PIX_W] <= wr_val;
                  if (wr_chg) changed_q <= 1'b1;
               end
               if (finish) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  conv_q  <= ~(changed_q | wr_chg);
               end else if (adv_cl) begin
                  k_q     <= k_q + 1'b1;
                  c_q     <= '0;
                  state_q <= LOAD;
               end else if (wr_en) begin
                  c_q     <= c_q + 2'd1;
                  state_q <= LOAD;
               end else if (state_q == LOAD) begin
                  state_q <= DIV;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.meanOut    = mean_q;
   assign bus.enabledOut = en_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.converged  = conv_q;

endmodule

// File: tb/tb_mean_update.sv
// Self-checking bench for mean_update: directed cases plus randomized runs against a
// plain-arithmetic reference model.
module tb_mean_update;

   localparam int T = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mean_update_if #(.T(T)) bus ();

   mean_update #(.T(T)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int unsigned acc[2][T][3];
   int unsigned cnt[2][T];
   int unsigned mean_in[T][3];
   logic [T-1:0] en_in;

   logic [24*T-1:0] exp_mean;
   logic [T-1:0]    exp_en;
   logic            exp_conv;
   int              exp_cyc;
   int              got_cyc;

   task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      en_in = '0;
      for (int k = 0; k < T; k++) begin
         for (int e = 0; e < 2; e++) begin
            cnt[e][k] = 0;
            for (int c = 0; c < 3; c++) acc[e][k][c] = 0;
         end
         for (int c = 0; c < 3; c++) mean_in[k][c] = 0;
      end
   endtask

   task automatic random_inputs();
      for (int k = 0; k < T; k++) begin
         en_in[k] = ($urandom_range(0, 3) != 0);
         for (int e = 0; e < 2; e++) begin
            cnt[e][k] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 4095);
            for (int c = 0; c < 3; c++)
               acc[e][k][c] = (cnt[e][k] == 0) ? 0 : $urandom_range(0, cnt[e][k] * 300);
         end
         for (int c = 0; c < 3; c++) mean_in[k][c] = $urandom_range(0, 255);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < T; k++) begin
         for (int e = 0; e < 2; e++) begin
            bus.counters[e*12*T + k*12 +: 12] = cnt[e][k][11:0];
            for (int c = 0; c < 3; c++)
               bus.accumolator[e*72*T + k*72 + c*24 +: 24] = acc[e][k][c][23:0];
         end
         for (int c = 0; c < 3; c++) bus.meanIn[k*24 + c*8 +: 8] = mean_in[k][c][7:0];
      end
      bus.enabledIn = en_in;
   endtask

   // Reference: merge, floor-divide, clamp at 255, track changes and cycle cost.
   task automatic model();
      int unsigned n, s, q;
      logic chg;
      chg     = 1'b0;
      exp_en  = en_in;
      exp_cyc = 1;
      for (int k = 0; k < T; k++) begin
         n = cnt[0][k] + cnt[1][k];
         for (int c = 0; c < 3; c++) exp_mean[k*24 + c*8 +: 8] = mean_in[k][c][7:0];
         if (!en_in[k] || n == 0) begin
            exp_en[k] = 1'b0;
            exp_cyc  += 1;
         end else begin
            for (int c = 0; c < 3; c++) begin
               s = acc[0][k][c] + acc[1][k][c];
               q = s / n;
               if (q > 255) begin
                  q = 255;
                  exp_cyc += 1;
               end else begin
                  exp_cyc += 9;
               end
               if (q != mean_in[k][c]) chg = 1'b1;
               exp_mean[k*24 + c*8 +: 8] = q[7:0];
            end
         end
      end
      exp_conv = ~chg;
   endtask

   task automatic run(input string tag);
      drive();
      model();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      got_cyc = 1;
      check({tag, ".busy_first"}, 384'(bus.busy), 384'(1'b1));
      while (!bus.done && got_cyc < 2000) begin
         @(posedge clk);
         #1;
         got_cyc++;
      end
      check({tag, ".done_cycle"}, 384'(got_cyc), 384'(exp_cyc));
      check({tag, ".mean"}, 384'(bus.meanOut), 384'(exp_mean));
      check({tag, ".enabled"}, 384'(bus.enabledOut), 384'(exp_en));
      check({tag, ".converged"}, 384'(bus.converged), 384'(exp_conv));
      @(posedge clk);
      #1;
      check({tag, ".busy_after"}, 384'(bus.busy), 384'(1'b0));
      check({tag, ".done_pulse"}, 384'(bus.done), 384'(1'b0));
   endtask

   initial begin
      bus.start       = 1'b0;
      bus.accumolator = '0;
      bus.counters    = '0;
      bus.meanIn      = '0;
      bus.enabledIn   = '0;
      reset           = 1'b0;
      #23;
      check("reset.mean", 384'(bus.meanOut), 384'(0));
      check("reset.enabled", 384'(bus.enabledOut), 384'(0));
      check("reset.busy", 384'(bus.busy), 384'(0));
      check("reset.done", 384'(bus.done), 384'(0));
      check("reset.converged", 384'(bus.converged), 384'(0));
      @(negedge clk);
      reset = 1'b1;

      // Saturation: B = 3000/10 clamps to 255.
      clear_inputs();
      en_in[0]     = 1'b1;
      acc[0][0][0] = 1000;
      acc[0][0][1] = 2000;
      acc[0][0][2] = 3000;
      cnt[0][0]    = 10;
      run("sat");
      check("sat.mean0", 384'(bus.meanOut[23:0]), 384'(24'hFF_C8_64));
      check("sat.en_const", 384'(bus.enabledOut), 384'(16'h0001));
      check("sat.conv_const", 384'(bus.converged), 384'(1'b0));

      // Cross-engine merge and latency: 1001/10 = 100 on every channel, no saturation.
      clear_inputs();
      en_in[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         acc[0][0][c] = 500;
         acc[1][0][c] = 501;
      end
      cnt[0][0] = 5;
      cnt[1][0] = 5;
      run("merge");
      check("merge.r", 384'(bus.meanOut[7:0]), 384'(8'd100));
      check("latency.done_at_43", 384'(got_cyc), 384'(43));

      // Zero-count cluster keeps its mean and is disabled.
      clear_inputs();
      en_in[0]      = 1'b1;
      en_in[3]      = 1'b1;
      acc[0][0][0]  = 777;
      cnt[0][0]     = 7;
      mean_in[3][0] = 'h56;
      mean_in[3][1] = 'h34;
      mean_in[3][2] = 'h12;
      run("zero");
      check("zero.mean3", 384'(bus.meanOut[3*24 +: 24]), 384'(24'h123456));
      check("zero.en3", 384'(bus.enabledOut[3]), 384'(1'b0));

      // Convergence: feed results back as meanIn, then perturb one channel.
      random_inputs();
      en_in[0]     = 1'b1;
      cnt[0][0]    = 9;
      acc[0][0][0] = 900;
      run("conv.first");
      for (int k = 0; k < T; k++)
         for (int c = 0; c < 3; c++) mean_in[k][c] = 32'(exp_mean[k*24 + c*8 +: 8]);
      run("conv.same");
      check("conv.same_const", 384'(bus.converged), 384'(1'b1));
      mean_in[0][0] = mean_in[0][0] ^ 1;
      run("conv.diff");
      check("conv.diff_const", 384'(bus.converged), 384'(1'b0));

      // Reset mid-operation, then a clean rerun must match the model.
      random_inputs();
      en_in[0] = 1'b1;
      cnt[1][0] = 3;
      drive();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (14) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrst.busy", 384'(bus.busy), 384'(0));
      check("midrst.mean", 384'(bus.meanOut), 384'(0));
      check("midrst.done", 384'(bus.done), 384'(0));
      check("midrst.enabled", 384'(bus.enabledOut), 384'(0));
      @(negedge clk);
      reset = 1'b1;
      run("midrst.rerun");

      // Randomized runs.
      for (int i = 0; i < 12; i++) begin
         random_inputs();
         run($sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
